// File: rtl/lc3_execute_stage_param.sv
// LC-3 execute stage: negedge operand latch, N-deep forwarding,
// ALU with iterative shift-add multiply, and branch forecast check.
module lc3_execute_stage_param #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int FWD_N  = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     I_valid,
  input  logic [DATA_W-1:0]        I_npc,
  input  logic                     I_sr1_en,
  input  logic                     I_sr2_en,
  input  logic [REG_AW-1:0]        I_sr1_addr,
  input  logic [REG_AW-1:0]        I_sr2_addr,
  input  logic [DATA_W-1:0]        I_sr1_val,
  input  logic [DATA_W-1:0]        I_sr2_val,
  input  logic                     I_dr_en,
  input  logic [REG_AW-1:0]        I_dr_addr,
  input  logic [2:0]               I_aluop,
  input  logic                     I_setcc,
  input  logic [1:0]               I_brmode,
  input  logic [2:0]               I_brmask,
  input  logic [DATA_W-1:0]        I_forecast_pc,
  input  logic [2:0]               cc_in,
  input  logic [FWD_N-1:0]         fwd_en,
  input  logic [FWD_N*REG_AW-1:0]  fwd_addr,
  input  logic [FWD_N*DATA_W-1:0]  fwd_data,
  output logic                     O_valid,
  output logic                     O_dr_en,
  output logic [REG_AW-1:0]        O_dr_addr,
  output logic                     O_setcc,
  output logic [DATA_W-1:0]        O_result,
  output logic [2:0]               O_cc,
  output logic                     busy,
  output logic                     need_cc,
  output logic                     forecast_fail,
  output logic [DATA_W-1:0]        checked_pc
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_PSA = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_PSB = 3'b111;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] npc;
    logic              sr1_en;
    logic              sr2_en;
    logic [REG_AW-1:0] sr1_addr;
    logic [REG_AW-1:0] sr2_addr;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              dr_en;
    logic [REG_AW-1:0] dr_addr;
    logic [2:0]        aluop;
    logic              setcc;
    logic [1:0]        brmode;
    logic [2:0]        brmask;
    logic [DATA_W-1:0] fcast;
  } ex_t;

  ex_t               ex_q, ex_d;
  state_e            st_q, st_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mc_q, mc_d;
  logic [DATA_W-1:0] mp_q, mp_d;
  logic [DATA_W-1:0] prod_q, prod_d;

  logic [DATA_W-1:0] eff_a, eff_b;
  logic [DATA_W-1:0] in_a, in_b;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] actual;
  logic [3:0]        sh;
  logic              sh_big;
  logic              cap;
  logic              take;
  logic              chk_br;

  // lowest index wins: scan from the oldest source down to the youngest
  function automatic logic [DATA_W-1:0] fwd_pick(
    input logic                    en,
    input logic [REG_AW-1:0]       addr,
    input logic [DATA_W-1:0]       dflt,
    input logic [FWD_N-1:0]        f_en,
    input logic [FWD_N*REG_AW-1:0] f_addr,
    input logic [FWD_N*DATA_W-1:0] f_data
  );
    logic [DATA_W-1:0] v;
    v = dflt;
    for (int i = FWD_N - 1; i >= 0; i--) begin
      if (en && f_en[i] &&
          f_addr[i*REG_AW +: REG_AW] == addr)
        v = f_data[i*DATA_W +: DATA_W];
    end
    return v;
  endfunction

  always_comb begin
    eff_a = fwd_pick(ex_q.sr1_en, ex_q.sr1_addr, ex_q.a,
                     fwd_en, fwd_addr, fwd_data);
    eff_b = fwd_pick(ex_q.sr2_en, ex_q.sr2_addr, ex_q.b,
                     fwd_en, fwd_addr, fwd_data);
    in_a  = fwd_pick(I_sr1_en, I_sr1_addr, I_sr1_val,
                     fwd_en, fwd_addr, fwd_data);
    in_b  = fwd_pick(I_sr2_en, I_sr2_addr, I_sr2_val,
                     fwd_en, fwd_addr, fwd_data);
  end

  always_comb begin
    ex_d   = ex_q;
    st_d   = st_q;
    cnt_d  = cnt_q;
    mc_d   = mc_q;
    mp_d   = mp_q;
    prod_d = prod_q;
    cap    = ~stall & (st_q == S_IDLE);

    if (st_q == S_RUN) begin
      prod_d = prod_q + (mp_q[0] ? mc_q : '0);
      mc_d   = mc_q << 1;
      mp_d   = mp_q >> 1;
      cnt_d  = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(DATA_W - 1))
        st_d = S_IDLE;
    end

    // keep forwarded operands once their source retires
    if (stall) begin
      ex_d.a = eff_a;
      ex_d.b = eff_b;
    end

    if (cap) begin
      ex_d.valid    = I_valid & ~flush;
      ex_d.npc      = I_npc;
      ex_d.sr1_en   = I_sr1_en;
      ex_d.sr2_en   = I_sr2_en;
      ex_d.sr1_addr = I_sr1_addr;
      ex_d.sr2_addr = I_sr2_addr;
      ex_d.a        = I_sr1_val;
      ex_d.b        = I_sr2_val;
      ex_d.dr_en    = I_dr_en;
      ex_d.dr_addr  = I_dr_addr;
      ex_d.aluop    = I_aluop;
      ex_d.setcc    = I_setcc;
      ex_d.brmode   = I_brmode;
      ex_d.brmask   = I_brmask;
      ex_d.fcast    = I_forecast_pc;
      if (I_valid & ~flush & (I_aluop == OP_MUL)) begin
        st_d   = S_RUN;
        cnt_d  = '0;
        prod_d = '0;
        mc_d   = in_a;
        mp_d   = in_b;
      end
    end

    if (flush) begin
      ex_d.valid = 1'b0;
      st_d       = S_IDLE;
    end
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      ex_q   <= '0;
      st_q   <= S_IDLE;
      cnt_q  <= '0;
      mc_q   <= '0;
      mp_q   <= '0;
      prod_q <= '0;
    end else begin
      ex_q   <= ex_d;
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      mc_q   <= mc_d;
      mp_q   <= mp_d;
      prod_q <= prod_d;
    end
  end

  always_comb begin
    sh     = eff_b[3:0];
    sh_big = int'(sh) >= DATA_W;
    result = '0;
    unique case (ex_q.aluop)
      OP_ADD: result = eff_a + eff_b;
      OP_AND: result = eff_a & eff_b;
      OP_NOT: result = ~eff_a;
      OP_PSA: result = eff_a;
      OP_SHL: result = sh_big ? '0 : eff_a << sh;
      OP_SHR: result = sh_big ? '0 : eff_a >> sh;
      OP_MUL: result = prod_q;
      OP_PSB: result = eff_b;
    endcase
  end

  always_comb begin
    O_cc = 3'b001;
    unique case (1'b1)
      result[DATA_W-1]: O_cc = 3'b100;
      (result == '0):   O_cc = 3'b010;
      default:          O_cc = 3'b001;
    endcase
  end

  always_comb begin
    take   = |(ex_q.brmask & cc_in);
    chk_br = (ex_q.brmode == 2'b01) | (ex_q.brmode == 2'b10);
    actual = ex_q.fcast;
    unique case (ex_q.brmode)
      2'b01:   actual = take ? result : ex_q.npc;
      2'b10:   actual = result;
      default: actual = ex_q.fcast;
    endcase
  end

  assign busy          = (st_q == S_RUN);
  assign O_valid       = ex_q.valid & ~busy;
  assign O_dr_en       = ex_q.dr_en;
  assign O_dr_addr     = ex_q.dr_addr;
  assign O_setcc       = ex_q.setcc;
  assign O_result      = result;
  assign need_cc       = (ex_q.brmode == 2'b01);
  assign checked_pc    = actual;
  assign forecast_fail = O_valid & ~stall & chk_br &
                         (actual != ex_q.fcast);

endmodule

// File: tb/tb_lc3_execute_stage_param.sv
// Directed bench for lc3_execute_stage_param (DATA_W=16,
// REG_AW=3, FWD_N=3) with hand-computed expected values.
module tb_lc3_execute_stage_param;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        I_valid;
  logic [15:0] I_npc;
  logic        I_sr1_en, I_sr2_en;
  logic [2:0]  I_sr1_addr, I_sr2_addr;
  logic [15:0] I_sr1_val, I_sr2_val;
  logic        I_dr_en;
  logic [2:0]  I_dr_addr;
  logic [2:0]  I_aluop;
  logic        I_setcc;
  logic [1:0]  I_brmode;
  logic [2:0]  I_brmask;
  logic [15:0] I_forecast_pc;
  logic [2:0]  cc_in;
  logic [2:0]  fwd_en;
  logic [8:0]  fwd_addr;
  logic [47:0] fwd_data;
  logic        O_valid, O_dr_en, O_setcc;
  logic [2:0]  O_dr_addr;
  logic [15:0] O_result;
  logic [2:0]  O_cc;
  logic        busy, need_cc, forecast_fail;
  logic [15:0] checked_pc;

  int errors = 0;
  int checks = 0;
  int n;

  logic [2:0]  v_op  [0:6] = '{3'b001, 3'b010, 3'b011,
                               3'b100, 3'b101, 3'b100,
                               3'b111};
  logic [15:0] v_a   [0:6] = '{16'hF0F0, 16'h00FF, 16'h0000,
                               16'h0001, 16'h8000, 16'h0001,
                               16'h0000};
  logic [15:0] v_b   [0:6] = '{16'h0FF0, 16'h0000, 16'h5555,
                               16'h0004, 16'h000F, 16'h0013,
                               16'h1234};
  logic [15:0] v_res [0:6] = '{16'h00F0, 16'hFF00, 16'h0000,
                               16'h0010, 16'h0001, 16'h0008,
                               16'h1234};
  logic [2:0]  v_cc  [0:6] = '{3'b001, 3'b100, 3'b010,
                               3'b001, 3'b001, 3'b001,
                               3'b001};

  lc3_execute_stage_param #(
    .DATA_W(16), .REG_AW(3), .FWD_N(3)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .I_valid(I_valid), .I_npc(I_npc),
    .I_sr1_en(I_sr1_en), .I_sr2_en(I_sr2_en),
    .I_sr1_addr(I_sr1_addr), .I_sr2_addr(I_sr2_addr),
    .I_sr1_val(I_sr1_val), .I_sr2_val(I_sr2_val),
    .I_dr_en(I_dr_en), .I_dr_addr(I_dr_addr),
    .I_aluop(I_aluop), .I_setcc(I_setcc),
    .I_brmode(I_brmode), .I_brmask(I_brmask),
    .I_forecast_pc(I_forecast_pc), .cc_in(cc_in),
    .fwd_en(fwd_en), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .O_valid(O_valid), .O_dr_en(O_dr_en),
    .O_dr_addr(O_dr_addr), .O_setcc(O_setcc),
    .O_result(O_result), .O_cc(O_cc), .busy(busy),
    .need_cc(need_cc), .forecast_fail(forecast_fail),
    .checked_pc(checked_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [2:0]  op,
                       input logic [15:0] a,
                       input logic [15:0] b);
    I_valid       = 1'b1;
    I_aluop       = op;
    I_sr1_val     = a;
    I_sr2_val     = b;
    I_sr1_en      = 1'b0;
    I_sr2_en      = 1'b0;
    I_sr1_addr    = 3'd0;
    I_sr2_addr    = 3'd0;
    I_dr_en       = 1'b1;
    I_dr_addr     = 3'd3;
    I_setcc       = 1'b1;
    I_brmode      = 2'b00;
    I_brmask      = 3'b000;
    I_npc         = 16'h3001;
    I_forecast_pc = 16'h1234;
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_valid"}, O_valid, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_ffail"}, forecast_fail, 0);
    chk({pfx, "_needcc"}, need_cc, 0);
    chk({pfx, "_result"}, O_result, 0);
    chk({pfx, "_cc"}, O_cc, 3'b010);
    chk({pfx, "_cpc"}, checked_pc, 0);
    chk({pfx, "_dren"}, O_dr_en, 0);
    chk({pfx, "_setcc"}, O_setcc, 0);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    instr(3'b000, 16'h0, 16'h0);
    I_valid = 1'b0; I_dr_en = 1'b0; I_setcc = 1'b0;
    cc_in = 3'b010;
    fwd_en = 3'b000; fwd_addr = '0; fwd_data = '0;
    @(posedge clk); #1;
    cyc();
    chk_reset("rst");
    reset = 1'b0;

    // ADD overflow into the sign bit
    instr(3'b000, 16'h7FFF, 16'h0001);
    cyc();
    chk("add_res", O_result, 16'h8000);
    chk("add_cc", O_cc, 3'b100);
    chk("add_valid", O_valid, 1);
    chk("add_draddr", O_dr_addr, 3'd3);
    chk("add_cpc", checked_pc, 16'h1234);
    chk("add_ffail", forecast_fail, 0);

    for (int i = 0; i < 7; i++) begin
      instr(v_op[i], v_a[i], v_b[i]);
      cyc();
      chk($sformatf("alu%0d_res", i), O_result, v_res[i]);
      chk($sformatf("alu%0d_cc", i), O_cc, v_cc[i]);
    end

    // all three sources hit R2; index 0 must win
    instr(3'b011, 16'h0005, 16'h0000);
    I_sr1_en = 1'b1; I_sr1_addr = 3'd2;
    fwd_en = 3'b111;
    fwd_addr = {3'd2, 3'd2, 3'd2};
    fwd_data = {16'h0033, 16'h0022, 16'h0011};
    cyc();
    chk("fwd_a", O_result, 16'h0011);
    stall = 1'b1;
    instr(3'b000, 16'h9999, 16'h0001);
    cyc();
    chk("fwd_stall0", O_result, 16'h0011);
    fwd_en = 3'b000;
    #1;
    chk("fwd_drop", O_result, 16'h0011);
    cyc();
    chk("fwd_stall1", O_result, 16'h0011);
    cyc();
    chk("fwd_stall2", O_result, 16'h0011);
    chk("fwd_valid", O_valid, 1);
    stall = 1'b0;

    instr(3'b111, 16'h0000, 16'h0007);
    I_sr2_en = 1'b1; I_sr2_addr = 3'd5;
    fwd_en = 3'b110;
    fwd_addr = {3'd5, 3'd5, 3'd5};
    cyc();
    chk("fwd_prio", O_result, 16'h0022);
    fwd_en = 3'b000;

    // flush alongside a valid instruction discards it
    instr(3'b000, 16'h0001, 16'h0002);
    flush = 1'b1;
    cyc();
    chk("flush_in_valid", O_valid, 0);
    flush = 1'b0;

    // 3 x 5 multiply
    instr(3'b110, 16'h0003, 16'h0005);
    cyc();
    chk("mul_busy", busy, 1);
    chk("mul_nvalid", O_valid, 0);
    instr(3'b000, 16'h0001, 16'h0001);
    n = 0;
    while (busy && n < 40) begin
      cyc();
      n++;
    end
    chk("mul_busy_cycles", n, 16);
    chk("mul_res", O_result, 16'h000F);
    chk("mul_valid", O_valid, 1);
    chk("mul_cc", O_cc, 3'b001);
    cyc();
    chk("post_mul_add", O_result, 16'h0002);

    // flush on the 5th RUN cycle
    instr(3'b110, 16'h0007, 16'h0009);
    cyc();
    instr(3'b000, 16'h0002, 16'h0003);
    repeat (4) cyc();
    chk("fl_busy_pre", busy, 1);
    flush = 1'b1;
    cyc();
    chk("fl_busy", busy, 0);
    chk("fl_valid", O_valid, 0);
    flush = 1'b0;
    cyc();
    chk("fl_next_res", O_result, 16'h0005);
    chk("fl_next_valid", O_valid, 1);

    // conditional branch, not taken
    instr(3'b011, 16'h4000, 16'h0000);
    I_brmode = 2'b01; I_brmask = 3'b100;
    I_npc = 16'h3001; I_forecast_pc = 16'h3050;
    cc_in = 3'b010;
    cyc();
    chk("br_nt_ffail", forecast_fail, 1);
    chk("br_nt_cpc", checked_pc, 16'h3001);
    chk("br_needcc", need_cc, 1);
    stall = 1'b1;
    #1;
    chk("br_stall_ffail", forecast_fail, 0);
    stall = 1'b0;
    I_forecast_pc = 16'h3001;
    cyc();
    chk("br_nt_ok", forecast_fail, 0);
    chk("br_nt_cpc2", checked_pc, 16'h3001);
    I_brmask = 3'b010;
    cyc();
    chk("br_t_ffail", forecast_fail, 1);
    chk("br_t_cpc", checked_pc, 16'h4000);
    I_brmode = 2'b10; I_brmask = 3'b000;
    I_forecast_pc = 16'h4000;
    cyc();
    chk("br_u_ffail", forecast_fail, 0);
    chk("br_u_cpc", checked_pc, 16'h4000);
    chk("br_u_needcc", need_cc, 0);

    // asynchronous reset mid-multiply
    instr(3'b110, 16'h0007, 16'h0009);
    cyc();
    cyc();
    cyc();
    chk("rmul_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk_reset("rmid");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lc3_execute_stage_param.md
# lc3_execute_stage_param

Parametrised execute stage for the LC-3 pipeline: latches decoded operands on the falling clock edge, resolves register hazards from `FWD_N` downstream sources, and computes the ALU result and condition codes. It adds an iterative multiply controlled by a state machine, and checks both taken and not-taken branch forecasts. It sits between decode and memory stages and generalises data width, register-address width and forwarding depth.

## Interface
- `DATA_W`, 16: datapath and PC width.
- `REG_AW`, 3: register address width.
- `FWD_N`, 3: number of forwarding sources. Index 0 is the youngest and has the highest priority.
- `clk` in 1: clock; all registers update on negedge.
- `reset` in 1: asynchronous, active-high reset.
- `stall` in 1: downstream hold; stage contents freeze.
- `flush` in 1: squash the instruction held in the stage.
- `I_valid` in 1: an incoming instruction is present.
- `I_npc` in DATA_W: PC+1 of the incoming instruction.
- `I_sr1_en`, `I_sr2_en` in 1: the source operand is a register and is eligible for forwarding.
- `I_sr1_addr`, `I_sr2_addr` in REG_AW: source register numbers.
- `I_sr1_val`, `I_sr2_val` in DATA_W: register-file value or immediate.
- `I_dr_en` in 1: instruction writes a register.
- `I_dr_addr` in REG_AW: destination register number.
- `I_aluop` in 3: operation select. 000 ADD, 001 AND, 010 NOT A, 011 PASS A, 100 SHL A by B[3:0], 101 SHR-logical, 110 MUL, 111 PASS B.
- `I_setcc` in 1: instruction updates CC.
- `I_brmode` in 2: 00 none, 01 conditional, 10 unconditional (target = result), 11 none.
- `I_brmask` in 3: n/z/p mask.
- `I_forecast_pc` in DATA_W: predicted next PC.
- `cc_in` in 3: architectural n/z/p.
- `fwd_en` in FWD_N: per-source write-valid.
- `fwd_addr` in FWD_N*REG_AW: packed destination numbers.
- `fwd_data` in FWD_N*DATA_W: packed result values.
- `O_valid` out 1: the result is valid this cycle.
- `O_dr_en` out 1; `O_dr_addr` out REG_AW; `O_setcc` out 1.
- `O_result` out DATA_W: ALU or product result.
- `O_cc` out 3: CC derived from `O_result`.
- `busy` out 1: multiply in progress; upstream must hold.
- `need_cc` out 1: latched `brmode` equals 01.
- `forecast_fail` out 1: mispredict.
- `checked_pc` out DATA_W: correct next PC.

## Operation
- **Capture.**
  - When `~stall & ~busy`, all `I_*` fields are latched.
  - The valid bit is loaded from `I_valid & ~flush`.
- **Forwarding.**
  - Effective A and B come from the lowest index i with `fwd_en[i]`, `src_en`, and `fwd_addr[i]==src_addr`.
  - Otherwise they come from the latched value.
  - On every stall edge, the effective A and B are written back into the latched operands, so forwarded data survives the source retiring.
- **ALU.** All operations produce DATA_W bits; carry is discarded. Shift counts ≥ DATA_W give 0.
- **Multiply state machine.** States are IDLE and RUN.
  - A MUL capture enters RUN and snapshots A and B. The counter and product are cleared.
  - Each RUN edge performs one shift-add step.
  - After DATA_W steps the machine returns to IDLE with the low DATA_W bits of the product held.
- **Condition codes.** `O_cc` is 100 if the result's MSB is set, 010 if the result is zero, otherwise 001.
- **Branch check.**
  - The actual next PC is:
    - mode 01: the result if `(brmask & cc_in) != 0`, else npc;
    - mode 10: the result;
    - otherwise: the forecast.
  - `checked_pc` is the actual next PC.
  - `forecast_fail = O_valid & ~stall & (mode==01 | mode==10) & (actual != forecast)`.
- **Priority.** reset > flush > stall.
  - Flush clears valid, forces IDLE (aborting any MUL) and drops `busy`.
  - A flush asserted together with `I_valid` discards the incoming instruction.

## Timing
- **Reset values:** valid 0, all latched fields 0, state IDLE.
  - `O_valid` 0, `busy` 0, `forecast_fail` 0, `need_cc` 0.
  - `O_result` 0, `O_cc` 010, `checked_pc` 0.
  - `O_dr_en` 0, `O_setcc` 0.
- **Single-cycle operations:** the result is combinational from the latched state after the capture negedge, i.e. one-stage latency.
- **MUL:**
  - `busy` rises at the capture negedge and stays high for exactly DATA_W cycles.
  - `O_valid` is 0 while in RUN and rises with the return to IDLE.
  - The stage re-captures at the first negedge with `busy` low.
- **Stall during RUN:** steps continue. Completion then holds the result until `stall` drops.
- **Reset asserted mid-RUN:** the machine returns to IDLE immediately and asynchronously.

## Test plan
- ADD with A=0x7FFF, B=0x0001 -> `O_result` 0x8000, `O_cc` 100, `O_valid` 1 one negedge after capture.
- Same-address forwarding: `fwd_en`=111, all three sources targeting R2 with data 0x11/0x22/0x33, instruction sourcing R2 -> A=0x0011. Then stall 2 cycles while `fwd_en` drops to 000 -> A is still 0x0011.
- MUL with 0x0003 × 0x0005 (DATA_W=16) -> `busy` high for 16 cycles, then `O_result` 0x000F, `O_valid` 1, `O_cc` 001.
- Flush on the 5th RUN cycle -> `busy` 0 and `O_valid` 0 on the next negedge; the next instruction is captured normally.
- Conditional branch, not taken: mask 100, `cc_in` 010, npc 0x3001, forecast 0x3050 -> `forecast_fail` 1, `checked_pc` 0x3001. Repeat with forecast 0x3001 -> `forecast_fail` 0.
- Assert `reset` mid-MUL -> every output equals its reset value immediately, without waiting for a clock edge.
